// File: rtl/mode_sequencer_if.sv
// Mode request / status bundle between the hood controllers and mode_sequencer.
// master drives enable and toggle requests; slave (the sequencer) returns the mode status.
interface mode_sequencer_if #(
    parameter int unsigned SEC_W = 8
);
    logic             enable;
    logic [3:0]       req;
    logic [1:0]       current_mode;
    logic             mode_changed;
    logic             cooldown_active;
    logic [SEC_W-1:0] sec_remaining;

    modport master (
        output enable, req,
        input  current_mode, mode_changed, cooldown_active, sec_remaining
    );

    modport slave (
        input  enable, req,
        output current_mode, mode_changed, cooldown_active, sec_remaining
    );
endinterface

// File: rtl/mode_sequencer.sv
// Exhaust hood fan mode FSM: request arbitration, hurricane run timer and cooldown run-on.
// Optional HURRICANE_ONCE_EN: THIRD may be entered from STANDBY only once per enable session.
module mode_sequencer #(
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned HURRICANE_SEC = 60,
    parameter int unsigned COOLDOWN_SEC  = 60,
    parameter int unsigned SEC_W         = 8
) (
    input logic             clk,
    input logic             rst,
    mode_sequencer_if.slave bus
);
    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {StStandby, StFirst, StSecond, StThird, StCooldown} state_e;

    state_e             state_q, state_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               changed_q, changed_d;
    logic [3:0]         legal, grant;
    logic               timed, tick;
`ifdef HURRICANE_ONCE_EN
    logic               used_q, used_d;
`endif

    function automatic logic [1:0] mode_of(state_e s);
        case (s)
            StFirst:  return 2'd1;
            StSecond: return 2'd2;
            StThird:  return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StStandby;
            sec_q     <= '0;
            presc_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            changed_q <= changed_d;
        end
    end

`ifdef HURRICANE_ONCE_EN
    always_ff @(posedge clk) begin
        if (rst) used_q <= 1'b0;
        else     used_q <= used_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        presc_d = '0;
        legal   = 4'b0000;
`ifdef HURRICANE_ONCE_EN
        used_d  = used_q;
`endif
        case (state_q)
`ifdef HURRICANE_ONCE_EN
            StStandby:         legal = used_q ? 4'b0110 : 4'b1110;
`else
            StStandby:         legal = 4'b1110;
`endif
            StFirst, StSecond: legal = 4'b0111;
            StThird:           legal = 4'b0001;
            default:           legal = 4'b0000;
        endcase
        grant = bus.req & legal;
        timed = (state_q == StThird) || (state_q == StCooldown);
        tick  = timed && (presc_q == PRESC_W'(TICK_DIV - 1));

        if (timed) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) sec_d = sec_q - 1'b1;
        end

        // Lowest legal bit wins; a grant for the current mode leaves state_d unchanged.
        if (grant[0])      state_d = (state_q == StThird) ? StCooldown : StStandby;
        else if (grant[1]) state_d = StFirst;
        else if (grant[2]) state_d = StSecond;
        else if (grant[3]) state_d = StThird;
        else if (tick && sec_q == SEC_W'(1))
            state_d = (state_q == StThird) ? StSecond : StStandby;

        if (state_d != state_q) begin
            presc_d = '0;
            case (state_d)
                StThird: begin
                    sec_d = SEC_W'(HURRICANE_SEC);
`ifdef HURRICANE_ONCE_EN
                    used_d = 1'b1;
`endif
                end
                StCooldown: sec_d = SEC_W'(COOLDOWN_SEC);
                default:    sec_d = '0;
            endcase
        end

        if (!bus.enable) begin
            state_d = StStandby;
            sec_d   = '0;
            presc_d = '0;
`ifdef HURRICANE_ONCE_EN
            used_d  = 1'b0;
`endif
        end

        changed_d = mode_of(state_d) != mode_of(state_q);
    end

    always_comb begin
        bus.current_mode    = mode_of(state_q);
        bus.mode_changed    = changed_q;
        bus.cooldown_active = (state_q == StCooldown);
        bus.sec_remaining   = sec_q;
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with a dwell-time based reference model checked every cycle.
module tb_mode_sequencer;
    localparam int TICK = 4;
    localparam int HSEC = 3;
    localparam int CSEC = 2;
`ifdef HURRICANE_ONCE_EN
    localparam bit ONCE = 1'b1;
`else
    localparam bit ONCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mode_sequencer_if #(.SEC_W(8)) bus ();

    mode_sequencer #(
        .TICK_DIV     (TICK),
        .HURRICANE_SEC(HSEC),
        .COOLDOWN_SEC (CSEC),
        .SEC_W        (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model: m_state 0..3 is the fan mode, 4 is cooldown; m_dwell counts cycles since entry.
    int m_state = 0;
    int m_dwell = 0;
    bit m_used  = 1'b0;
    bit m_chg   = 1'b0;
    bit m_valid = 1'b0;

    function automatic int mode_of(int st);
        return (st == 4) ? 0 : st;
    endfunction

    function automatic bit legal(int st, int i, bit used);
        case (st)
            0:       return (i != 0) && !(i == 3 && ONCE && used);
            1, 2:    return i != 3;
            3:       return i == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int limit(int st);
        return (st == 3) ? HSEC * TICK : CSEC * TICK;
    endfunction

    function automatic int exp_sec(int st, int dwell);
        if (st == 3) return HSEC - dwell / TICK;
        if (st == 4) return CSEC - dwell / TICK;
        return 0;
    endfunction

    always @(posedge clk) begin
        int prev;
        int win;
        int nxt;
        prev = mode_of(m_state);
        if (rst) begin
            m_state = 0; m_dwell = 0; m_used = 0; m_chg = 0;
        end else if (!bus.enable) begin
            m_state = 0; m_dwell = 0; m_used = 0;
            m_chg = (prev != 0);
        end else begin
            win = -1;
            for (int i = 0; i < 4; i++)
                if (win < 0 && bus.req[i] && legal(m_state, i, m_used)) win = i;
            nxt = m_state;
            if (win >= 0) nxt = (m_state == 3) ? 4 : win;
            else if (m_state >= 3 && m_dwell + 1 == limit(m_state)) nxt = (m_state == 3) ? 2 : 0;
            if (nxt != m_state) begin
                if (nxt == 3) m_used = 1'b1;
                m_dwell = 0;
            end else begin
                m_dwell++;
            end
            m_state = nxt;
            m_chg = (mode_of(m_state) != prev);
        end
        m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_mode", 32'(bus.current_mode), 32'(mode_of(m_state)));
            chk("cyc_changed", 32'(bus.mode_changed), 32'(m_chg));
            chk("cyc_cooldown", 32'(bus.cooldown_active), 32'(m_state == 4));
            chk("cyc_sec", 32'(bus.sec_remaining), 32'(exp_sec(m_state, m_dwell)));
        end
    end

    task automatic pulse(input logic [3:0] r);
        bus.req = r;
        @(posedge clk); #1;
        bus.req = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enable_low(input logic [3:0] r);
        bus.enable = 1'b0;
        bus.req    = r;
        @(posedge clk); #1;
        bus.enable = 1'b1;
        bus.req    = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b1;
        bus.req = 4'b0000;
        idle(2);
        chk("rst_mode", 32'(bus.current_mode), 0);
        chk("rst_changed", 32'(bus.mode_changed), 0);
        chk("rst_cooldown", 32'(bus.cooldown_active), 0);
        chk("rst_sec", 32'(bus.sec_remaining), 0);
        rst = 1'b0;
        idle(1);

        // Basic toggles
        pulse(4'b0010);
        chk("to_first", 32'(bus.current_mode), 1);
        chk("to_first_pulse", 32'(bus.mode_changed), 1);
        idle(1);
        chk("pulse_one_cycle", 32'(bus.mode_changed), 0);
        pulse(4'b0001);
        chk("to_standby", 32'(bus.current_mode), 0);
        chk("to_standby_pulse", 32'(bus.mode_changed), 1);
        pulse(4'b0001);
        chk("repeat_no_pulse", 32'(bus.mode_changed), 0);

        // Hurricane timeout: 12 cycles in THIRD
        pulse(4'b1000);
        chk("third_mode", 32'(bus.current_mode), 3);
        chk("third_sec", 32'(bus.sec_remaining), 3);
        idle(4);
        chk("third_sec_after_tick", 32'(bus.sec_remaining), 2);
        idle(7);
        chk("third_before_exit", 32'(bus.current_mode), 3);
        chk("third_sec_last", 32'(bus.sec_remaining), 1);
        idle(1);
        chk("timeout_mode", 32'(bus.current_mode), 2);
        chk("timeout_pulse", 32'(bus.mode_changed), 1);
        chk("timeout_sec", 32'(bus.sec_remaining), 0);

        // Second hurricane request from STANDBY
        pulse(4'b0001);
        pulse(4'b1000);
        if (ONCE) begin
            chk("once_blocked", 32'(bus.current_mode), 0);
            enable_low(4'b0000);
            pulse(4'b1000);
            chk("once_rearmed", 32'(bus.current_mode), 3);
        end else begin
            chk("second_third", 32'(bus.current_mode), 3);
        end

        // Cooldown
        idle(2);
        pulse(4'b0001);
        chk("cool_mode", 32'(bus.current_mode), 0);
        chk("cool_pulse", 32'(bus.mode_changed), 1);
        chk("cool_active", 32'(bus.cooldown_active), 1);
        chk("cool_sec", 32'(bus.sec_remaining), 2);
        pulse(4'b0010);
        chk("cool_ignores_req", 32'(bus.current_mode), 0);
        idle(6);
        chk("cool_still_active", 32'(bus.cooldown_active), 1);
        idle(1);
        chk("cool_done", 32'(bus.cooldown_active), 0);
        chk("cool_done_no_pulse", 32'(bus.mode_changed), 0);

        // Arbitration
        pulse(4'b0110);
        chk("arb_lowest", 32'(bus.current_mode), 1);
        pulse(4'b1000);
        chk("arb_first_no_third", 32'(bus.current_mode), 1);
        chk("arb_no_pulse", 32'(bus.mode_changed), 0);
        pulse(4'b1001);
        chk("arb_standby", 32'(bus.current_mode), 0);

        // enable=0 during cooldown: silent exit
        enable_low(4'b0000);
        pulse(4'b1000);
        pulse(4'b0001);
        chk("cool_again", 32'(bus.cooldown_active), 1);
        enable_low(4'b0010);
        chk("dis_cool_mode", 32'(bus.current_mode), 0);
        chk("dis_cool_no_pulse", 32'(bus.mode_changed), 0);
        chk("dis_cool_inactive", 32'(bus.cooldown_active), 0);
        chk("dis_cool_sec", 32'(bus.sec_remaining), 0);

        // enable=0 from SECOND pulses
        pulse(4'b0100);
        enable_low(4'b0100);
        chk("dis_second_mode", 32'(bus.current_mode), 0);
        chk("dis_second_pulse", 32'(bus.mode_changed), 1);

        // Reset in THIRD
        pulse(4'b1000);
        chk("pre_rst_third", 32'(bus.current_mode), 3);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_mode", 32'(bus.current_mode), 0);
        chk("mid_rst_sec", 32'(bus.sec_remaining), 0);
        chk("mid_rst_changed", 32'(bus.mode_changed), 0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
